pool_sched: RTL

- Sequencer for the max-pooling datapath (5-sample non-overlapping windows, 8-bit signed).
- Reads each channel's feature samples from the feature buffer and streams them into the pooling unit with correct enable framing.
- Captures each pooled result at its fixed result cycle and writes it to the output buffer.
- Processes cfg_ch channels back-to-back per start; reports busy/done to the layer controller.

---
 rtl/pool_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pool_sched.sv
// pool_sched: sequencer for the 5-sample max-pooling datapath.
// Streams each channel's samples from the feature buffer into the pooling unit, frames
// pool_en with one trailing flush cycle, captures each pooled result at its fixed result
// cycle and writes it to the output buffer. Handles cfg_ch channels back-to-back.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle request, accepted only when idle
//   cfg_len, cfg_ch    windows per channel, channel count (latched on accepted start)
//   in_base, out_base  feature / output buffer base addresses (latched on accepted start)
//   rd_en, rd_addr     feature buffer read port; rd_data returns one cycle later
//   pool_en, pool_x    pooling unit enable and sample
//   pool_y             pooling unit result
//   wr_en, wr_addr,    output buffer write port
//   wr_data
//   busy, done         status to the layer controller
module pool_sched #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned CH_W    = 6,
  parameter int unsigned POOL    = 5,
  parameter int unsigned RES_OFS = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pool_en,
  output logic [DATA_W-1:0] pool_x,
  input  logic [DATA_W-1:0] pool_y,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  // Channel-local cycle counter must reach POOL*W+3.
  localparam int unsigned TW = LEN_W + $clog2(POOL) + 2;
  localparam int unsigned CW = $clog2(RES_OFS + POOL + 2);

  // Countdown to the next result cycle: first result RES_OFS+1 cycles after the first read,
  // then one every POOL cycles.
  localparam logic [CW-1:0] WcdFirst = CW'(RES_OFS + 1);
  localparam logic [CW-1:0] WcdNext  = CW'(POOL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [CW-1:0]     wcd_q, wcd_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CH_W-1:0]   chn_q, chn_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  // Channels are laid out contiguously, so the pointers simply keep counting across
  // channels; this equals base + ch*POOL*W + i truncated to ADDR_W.
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [TW-1:0] n_rd;
  assign n_rd = TW'(len_q) * TW'(POOL);

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    wcd_d    = wcd_q;
    len_d    = len_q;
    chn_d    = chn_q;
    ch_d     = ch_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_en    = 1'b0;
    pool_en  = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d    = cfg_len;
          chn_d    = cfg_ch;
          rd_ptr_d = in_base;
          wr_ptr_d = out_base;
          ch_d     = '0;
          t_d      = '0;
          wcd_d    = WcdFirst;
          state_d  = (cfg_len == '0 || cfg_ch == '0) ? StDone : StRun;
        end
      end
      StRun, StDrain: begin
        busy = 1'b1;
        t_d  = t_q + TW'(1);
        if (wcd_q == '0) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          wcd_d    = WcdNext;
        end else begin
          wcd_d = wcd_q - CW'(1);
        end

        if (state_q == StRun) begin
          rd_en    = 1'b1;
          // Read data lands one cycle later, so pool_en lags rd_en by one cycle.
          pool_en  = (t_q != '0);
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          if (t_q == n_rd - TW'(1)) begin
            state_d = StDrain;
          end
        end else begin
          // Includes the single flush cycle after the last sample.
          pool_en = (t_q <= n_rd + TW'(1));
          if (t_q == n_rd + TW'(3)) begin
            // Last result of this channel is being written now.
            if (ch_q == chn_q - CH_W'(1)) begin
              state_d = StDone;
            end else begin
              ch_d    = ch_q + CH_W'(1);
              t_d     = '0;
              wcd_d   = WcdFirst;
              state_d = StRun;
            end
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Data/address outputs are forced to zero outside their strobes.
  assign rd_addr = rd_en   ? rd_ptr_q : '0;
  assign pool_x  = pool_en ? rd_data  : '0;
  assign wr_addr = wr_en   ? wr_ptr_q : '0;
  assign wr_data = wr_en   ? pool_y   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      t_q      <= '0;
      wcd_q    <= '0;
      len_q    <= '0;
      chn_q    <= '0;
      ch_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      wcd_q    <= wcd_d;
      len_q    <= len_d;
      chn_q    <= chn_d;
      ch_q     <= ch_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule
